// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_pkg;

  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_RUN  = 1'b1
  } phase_t;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;

  // Sequential successor; wraps naturally modulo 2^32.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_fetch_pc_gen.sv
// Program-counter sequencer: phase, PC, pending-branch latch and redirect priority.
module if_fetch_pc_gen
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        rom_ce,
  output logic [31:0] rom_addr
);

  phase_t      phase_reg;
  logic        ce_reg;
  logic [31:0] pc_reg;
  logic        pend_valid_reg;
  logic [31:0] pend_target_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg       <= PH_IDLE;
      ce_reg          <= CHIP_DISABLE;
      pc_reg          <= RESET_PC;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= ZERO_WORD;
    end else begin
      case (phase_reg)
        PH_IDLE: begin
          // First fetch after reset is RESET_PC itself, so the PC does not move here.
          phase_reg <= PH_RUN;
          ce_reg    <= CHIP_ENABLE;
        end
        default: begin
          ce_reg <= CHIP_ENABLE;
          if (flush) begin
            pc_reg         <= new_pc;
            pend_valid_reg <= 1'b0;
          end else if (stall_pc) begin
            // A branch resolved while the PC is frozen is remembered, not dropped.
            if (branch_flag) begin
              pend_valid_reg  <= 1'b1;
              pend_target_reg <= branch_target;
            end
          end else if (branch_flag) begin
            pc_reg         <= branch_target;
            pend_valid_reg <= 1'b0;
          end else if (pend_valid_reg) begin
            pc_reg         <= pend_target_reg;
            pend_valid_reg <= 1'b0;
          end else begin
            pc_reg <= next_seq_pc(pc_reg);
          end
        end
      endcase
    end
  end

  assign rom_ce   = ce_reg;
  assign rom_addr = pc_reg;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC sequencer driving the ROM plus the IF/ID pipeline register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic [31:0] rom_inst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  logic [31:0] id_pc_reg;
  logic [31:0] id_inst_reg;

  if_fetch_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk          (clk),
    .rst          (rst),
    .stall_pc     (stall_pc),
    .flush        (flush),
    .new_pc       (new_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .rom_ce       (rom_ce),
    .rom_addr     (rom_addr)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc_reg   <= ZERO_WORD;
      id_inst_reg <= ZERO_WORD;
    end else if (stall_if && !stall_id) begin
      id_pc_reg   <= ZERO_WORD;
      id_inst_reg <= ZERO_WORD;
    end else if (!stall_if) begin
      // With the ROM disabled the decoder must see a NOP, not a stale address.
      id_pc_reg   <= rom_ce ? rom_addr : ZERO_WORD;
      id_inst_reg <= rom_ce ? rom_inst : ZERO_WORD;
    end
  end

  assign id_pc   = id_pc_reg;
  assign id_inst = id_inst_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch against a behavioural fetch model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_pc = 1'b0, stall_if = 1'b0, stall_id = 1'b0, flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] rom_inst;
  logic        rom_ce;
  logic [31:0] rom_addr, id_pc, id_inst;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural model state
  logic        m_run = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic        m_pend = 1'b0;
  logic [31:0] m_ptgt = 32'h0;
  logic [31:0] m_idpc = 32'h0;
  logic [31:0] m_idinst = 32'h0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    if (w < 30'd4) return 32'h11 * ({2'b0, w} + 32'd1);
    return {a[31:2], 2'b00} ^ 32'hA5C3_0F0F ^ {a[24:0], 7'h55};
  endfunction

  assign rom_inst = rom_fn(rom_addr);

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_pc(stall_pc), .stall_if(stall_if), .stall_id(stall_id),
    .flush(flush), .new_pc(new_pc), .branch_flag(branch_flag), .branch_target(branch_target),
    .rom_inst(rom_inst), .rom_ce(rom_ce), .rom_addr(rom_addr), .id_pc(id_pc), .id_inst(id_inst)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and queue what the DUT must show after the edge.
  task automatic cyc(input logic r, input logic sp, input logic si, input logic sd,
                     input logic fl, input logic [31:0] np, input logic bf, input logic [31:0] bt);
    exp_t e;
    @(negedge clk);
    rst = r; stall_pc = sp; stall_if = si; stall_id = sd;
    flush = fl; new_pc = np; branch_flag = bf; branch_target = bt;
    if (r) begin
      m_run = 0; m_pc = 32'h0; m_pend = 0; m_ptgt = 32'h0; m_idpc = 0; m_idinst = 0;
    end else begin
      if (fl || (si && !sd)) begin
        m_idpc = 0; m_idinst = 0;
      end else if (!si) begin
        m_idpc   = m_run ? m_pc : 32'h0;
        m_idinst = m_run ? rom_fn(m_pc) : 32'h0;
      end
      if (!m_run) m_run = 1;
      else if (fl) begin m_pc = np; m_pend = 0; end
      else if (sp) begin if (bf) begin m_pend = 1; m_ptgt = bt; end end
      else if (bf) begin m_pc = bt; m_pend = 0; end
      else if (m_pend) begin m_pc = m_ptgt; m_pend = 0; end
      else m_pc = m_pc + 32'd4;
    end
    e.ce = m_run; e.addr = m_pc; e.pc = m_idpc; e.inst = m_idinst;
    exp_q.push_back(e);
    $display("cyc rst=%0b sp=%0b si=%0b sid=%0b fl=%0b bf=%0b exp ce=%0b addr=%h id_pc=%h id_inst=%h",
             r, sp, si, sd, fl, bf, e.ce, e.addr, e.pc, e.inst);
  endtask

  // Monitor: every edge that has a queued expectation is compared.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rom_ce", {31'b0, rom_ce}, {31'b0, e.ce});
      chk("rom_addr", rom_addr, e.addr);
      chk("id_pc", id_pc, e.pc);
      chk("id_inst", id_inst, e.inst);
    end
  end

  function automatic logic [31:0] rnd_target();
    if ($urandom_range(0, 4) == 0) return 32'hFFFF_FFF0 + 32'd4 * $urandom_range(0, 3);
    return $urandom & 32'h0000_0FFC;
  endfunction

  initial begin
    logic r, sp, si, sd, fl, bf;
    // Reset then release: ce rises, addr 0,4,8
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Branch at PC=8 to 0x100, delay slot flows
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Stall 3 cycles with branch pulse in the first
    cyc(0, 1, 1, 1, 0, 0, 1, 32'h200);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Bubble, then hold
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    // Pending branch discarded by flush with simultaneous branch+stall
    cyc(0, 1, 1, 1, 0, 0, 1, 32'h300);
    cyc(0, 1, 1, 1, 1, 32'h180, 1, 32'h400);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Wrap past 0xFFFF_FFFC
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Mid-run reset with everything else asserted
    cyc(1, 1, 1, 0, 1, 32'h500, 1, 32'h600);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      sp = ($urandom_range(0, 99) < 25);
      si = sp ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      sd = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 99) < 5);
      bf = ($urandom_range(0, 99) < 20);
      cyc(r, sp, si, sd, fl, rnd_target(), bf, rnd_target());
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
